mesh_output_interface: RTL and testbench

MESH_OUTPUT_INTERFACE -- requirements
Module: mesh_output_interface

---
 rtl/mesh_output_interface.sv | 132 +++++++++++++
 tb/tb_mesh_output_interface.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_output_interface.sv
// Mesh result collector: gathers south/east edge results into a FIFO
// and streams them to the host, tracking job progress and lost results.
module mesh_output_interface #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  result_count,
  input  logic        south_valid,
  input  logic [31:0] south_data,
  input  logic        east_valid,
  input  logic [31:0] east_data,
  output logic        stall_mesh,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]    state;
  logic [7:0]    remaining;
  logic [7:0]    rem_next;
  logic          ovf_q;
  logic          stall_q;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] free_slots;
  logic          collect;
  logic          s_wr;
  logic          e_wr;
  logic          pop;
  logic          lost;

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rptr] : '0;
  assign busy       = (state == COLLECT) || (state == DRAIN);
  assign done       = (state == DONE);
  assign overflow   = ovf_q;
  assign stall_mesh = stall_q;

  // Lane acceptance: south claims a slot first, east needs a second one.
  always_comb begin
    collect    = (state == COLLECT);
    free_slots = DEPTH_C - count;
    s_wr       = 1'b0;
    e_wr       = 1'b0;
    lost       = 1'b0;
    pop        = out_valid && out_ready;
    s_wr = collect && south_valid &&
           (free_slots != '0) && (remaining != 8'd0);
    if (s_wr) begin
      e_wr = collect && east_valid &&
             (free_slots >= CW'(2)) && (remaining >= 8'd2);
    end else begin
      e_wr = collect && east_valid &&
             (free_slots != '0) && (remaining != 8'd0);
    end
    if (collect) begin
      lost = (south_valid && !s_wr) || (east_valid && !e_wr);
    end else if (state == DRAIN) begin
      lost = south_valid || east_valid;
    end
    count_next = count + CW'(s_wr) + CW'(e_wr) - CW'(pop);
    rem_next   = remaining - 8'(s_wr) - 8'(e_wr);
  end

  // Job sequencing, remaining-result counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= 8'd0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= result_count;
            ovf_q     <= 1'b0;
            state     <= (result_count == 8'd0) ? DONE : COLLECT;
          end
        end
        COLLECT: begin
          remaining <= rem_next;
          if (lost) ovf_q <= 1'b1;
          if (rem_next == 8'd0) state <= DRAIN;
        end
        DRAIN: begin
          if (lost) ovf_q <= 1'b1;
          if (count_next == '0) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and registered backpressure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      stall_q <= 1'b0;
    end else begin
      wptr    <= wptr + AW'(s_wr) + AW'(e_wr);
      rptr    <= rptr + AW'(pop);
      count   <= count_next;
      stall_q <= (DEPTH_C - count_next) < CW'(2);
    end
  end

  // Storage: south lands first so it is the older entry.
  always_ff @(posedge clk) begin
    if (s_wr) mem[wptr] <= south_data;
    if (e_wr) mem[s_wr ? wptr + AW'(1) : wptr] <= east_data;
  end

endmodule

// File: tb/tb_mesh_output_interface.sv
// Bench for mesh_output_interface: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_mesh_output_interface;

  localparam int DEPTH = 8;
  localparam int P_IDLE = 0;
  localparam int P_COLLECT = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  result_count = 8'd0;
  logic        south_valid = 1'b0;
  logic [31:0] south_data = 32'd0;
  logic        east_valid = 1'b0;
  logic [31:0] east_data = 32'd0;
  logic        out_ready = 1'b0;
  logic        stall_mesh;
  logic        out_valid;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  bit [31:0] m_q[$];
  int        m_rem = 0;
  bit        m_ovf = 0;
  int        m_ph = P_IDLE;
  bit        m_stall = 0;

  bit [31:0] got[$];
  int        cyc = 0;
  int        last_pop_cyc = -1;
  int        done_cyc = -1;
  bit        seen_done = 0;
  bit        seen_busy = 0;

  mesh_output_interface #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .result_count(result_count),
    .south_valid(south_valid),
    .south_data(south_data),
    .east_valid(east_valid),
    .east_data(east_data),
    .stall_mesh(stall_mesh),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .busy(busy),
    .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input bit st, input bit [7:0] rc,
                      input bit sv, input bit [31:0] sd,
                      input bit ev, input bit [31:0] ed,
                      input bit rdy, input bit rst);
    int pre;
    int free;
    bit do_pop;
    bit [31:0] wq[$];
    start = st; result_count = rc;
    south_valid = sv; south_data = sd;
    east_valid = ev; east_data = ed;
    out_ready = rdy; reset_n = !rst;
    if (!rst && out_valid && rdy) begin
      got.push_back(out_data);
      last_pop_cyc = cyc + 1;
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_q.delete(); m_rem = 0; m_ovf = 0;
      m_ph = P_IDLE; m_stall = 0;
    end else begin
      pre = m_q.size();
      do_pop = (pre > 0) && rdy;
      case (m_ph)
        P_IDLE: begin
          if (st) begin
            m_rem = rc; m_ovf = 0;
            m_ph = (rc == 0) ? P_DONE : P_COLLECT;
          end
        end
        P_COLLECT: begin
          free = DEPTH - pre;
          if (sv) begin
            if (free > 0 && m_rem > 0) begin
              wq.push_back(sd); free--; m_rem--;
            end else m_ovf = 1;
          end
          if (ev) begin
            if (free > 0 && m_rem > 0) begin
              wq.push_back(ed); free--; m_rem--;
            end else m_ovf = 1;
          end
          if (m_rem == 0) m_ph = P_DRAIN;
        end
        P_DRAIN: begin
          if (sv || ev) m_ovf = 1;
          if (pre - int'(do_pop) == 0) m_ph = P_DONE;
        end
        default: m_ph = P_IDLE;
      endcase
      if (do_pop) void'(m_q.pop_front());
      foreach (wq[i]) m_q.push_back(wq[i]);
      m_stall = (DEPTH - m_q.size()) < 2;
    end
    #1;
    if (done && !seen_done) begin
      seen_done = 1; done_cyc = cyc;
    end
    if (busy) seen_busy = 1;
  endtask

  task automatic idle(input bit rdy);
    tick(0, 0, 0, 0, 0, 0, rdy, 0);
  endtask

  task automatic tb_reset();
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    got.delete();
    seen_done = 0; seen_busy = 0;
    done_cyc = -1; last_pop_cyc = -1;
  endtask

  task automatic drain_until_done();
    for (int i = 0; i < 40 && !seen_done; i++) idle(1);
  endtask

  task automatic test_reset();
    tb_reset();
    checks++;
    if ({out_valid, busy, done, overflow, stall_mesh} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {out_valid, busy, done, overflow, stall_mesh});
    end
    checks++;
    if (out_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", out_data);
    end
  endtask

  task automatic test_arrival_order();
    bit [31:0] exp[$] = '{32'h11, 32'h22, 32'h33, 32'h44};
    bit bad = 0;
    tb_reset();
    tick(1, 4, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 1, 32'h11, 0, 0, 1, 0);
    tick(0, 0, 1, 32'h22, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 1, 32'h33, 1, 0);
    tick(0, 0, 0, 0, 1, 32'h44, 1, 0);
    drain_until_done();
    if (got.size() != exp.size()) bad = 1;
    else foreach (exp[i]) if (got[i] !== exp[i]) bad = 1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL order4 got=%p exp=%p", got, exp);
    end
    checks++;
    if (!seen_done || done_cyc != last_pop_cyc) begin
      failures++;
      $display("FAIL done_timing got=%0d exp=%0d", done_cyc, last_pop_cyc);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL order4_ovf got=%b exp=0", overflow);
    end
  endtask

  task automatic test_same_cycle();
    tb_reset();
    tick(1, 2, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 32'hA, 1, 32'hB, 0, 0);
    checks++;
    if (busy !== 1'b1 || out_data !== 32'hA || overflow !== 1'b0) begin
      failures++;
      $display("FAIL pair_head got=%h/%b exp=0000000a/1", out_data, busy);
    end
    idle(1);
    checks++;
    if (out_data !== 32'hB) begin
      failures++;
      $display("FAIL pair_second got=%h exp=0000000b", out_data);
    end
    drain_until_done();
    checks++;
    if (got.size() != 2 || !seen_done) begin
      failures++;
      $display("FAIL pair_done got=%0d exp=2", got.size());
    end
  endtask

  task automatic test_full();
    bit [31:0] exp[$];
    bit bad = 0;
    tb_reset();
    tick(1, 10, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      tick(0, 0, 1, i, 0, 0, 0, 0);
      if (i == 6) begin
        checks++;
        if (stall_mesh !== 1'b0) begin
          failures++;
          $display("FAIL stall_6 got=%b exp=0", stall_mesh);
        end
      end
      if (i == 7) begin
        checks++;
        if (stall_mesh !== 1'b1) begin
          failures++;
          $display("FAIL stall_7 got=%b exp=1", stall_mesh);
        end
      end
      if (i == 8) begin
        checks++;
        if (overflow !== 1'b0 || stall_mesh !== 1'b1) begin
          failures++;
          $display("FAIL full_8 got=%b%b exp=01", overflow, stall_mesh);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL drop_9 got=%b exp=1", overflow);
    end
    idle(1); idle(1); idle(1);
    tick(0, 0, 1, 10, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 1, 11, 1, 0);
    drain_until_done();
    for (int i = 1; i <= 8; i++) exp.push_back(i);
    exp.push_back(10); exp.push_back(11);
    if (got.size() != exp.size()) bad = 1;
    else foreach (exp[i]) if (got[i] !== exp[i]) bad = 1;
    checks++;
    if (bad || !seen_done) begin
      failures++;
      $display("FAIL full_stream got=%p exp=%p", got, exp);
    end
  endtask

  task automatic test_remaining_one();
    tb_reset();
    tick(1, 1, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 1, 32'h55, 1, 32'h66, 1, 0);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL rem1_ovf got=%b exp=1", overflow);
    end
    drain_until_done();
    checks++;
    if (got.size() != 1 || got[0] !== 32'h55) begin
      failures++;
      $display("FAIL rem1_data got=%p exp=55", got);
    end
    checks++;
    if (!seen_done || done_cyc != last_pop_cyc) begin
      failures++;
      $display("FAIL rem1_done got=%0d exp=%0d", done_cyc, last_pop_cyc);
    end
  endtask

  task automatic test_zero_count();
    tb_reset();
    tick(1, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_done got=%b%b%b exp=100", done, busy, out_valid);
    end
    idle(1);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL zero_pulse got=%b exp=0", done);
    end
    idle(1);
    checks++;
    if (seen_busy) begin
      failures++;
      $display("FAIL zero_busy got=1 exp=0");
    end
  endtask

  task automatic test_reset_mid_job();
    tb_reset();
    tick(1, 8, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 32'hE0 + i, 0, 0, 0, 0);
    tick(0, 0, 1, 32'hEE, 0, 0, 0, 1);
    checks++;
    if ({out_valid, busy, overflow} !== 3'b000) begin
      failures++;
      $display("FAIL midrst got=%b exp=000", {out_valid, busy, overflow});
    end
    got.delete(); seen_done = 0; done_cyc = -1;
    tick(1, 2, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 1, 32'hC1, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 1, 32'hC2, 1, 0);
    drain_until_done();
    checks++;
    if (got.size() != 2 || got[0] !== 32'hC1 || got[1] !== 32'hC2) begin
      failures++;
      $display("FAIL midrst_job got=%p exp=c1,c2", got);
    end
    checks++;
    if (!seen_done || overflow !== 1'b0) begin
      failures++;
      $display("FAIL midrst_end got=%b/%b exp=1/0", seen_done, overflow);
    end
  endtask

  task automatic test_random();
    int rdy_pct = 60;
    int lane_pct = 50;
    bit st, sv, ev, rdy, rst;
    bit [7:0] rc;
    bit [31:0] exp_d;
    bit [4:0] exp_f;
    tb_reset();
    for (int n = 0; n < 3000; n++) begin
      if (m_ph == P_IDLE && $urandom_range(0, 3) == 0) begin
        rdy_pct = $urandom_range(10, 100);
        lane_pct = $urandom_range(20, 90);
      end
      st = (m_ph == P_IDLE) ? ($urandom_range(0, 2) == 0)
                            : ($urandom_range(0, 30) == 0);
      rc = 8'($urandom_range(0, 20));
      sv = $urandom_range(0, 99) < lane_pct;
      ev = $urandom_range(0, 99) < lane_pct;
      rdy = $urandom_range(0, 99) < rdy_pct;
      rst = ($urandom_range(0, 299) == 0);
      tick(st, rc, sv, $urandom, ev, $urandom, rdy, rst);
      exp_d = (m_q.size() != 0) ? m_q[0] : 32'd0;
      exp_f = {m_q.size() != 0,
               m_ph == P_COLLECT || m_ph == P_DRAIN,
               m_ph == P_DONE, m_ovf, m_stall};
      checks++;
      if ({out_valid, busy, done, overflow, stall_mesh} !== exp_f ||
          out_data !== exp_d) begin
        failures++;
        $display("FAIL rand cyc=%0d got=%b/%h exp=%b/%h", cyc,
                 {out_valid, busy, done, overflow, stall_mesh}, out_data,
                 exp_f, exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arrival_order();
    test_same_cycle();
    test_full();
    test_remaining_one();
    test_zero_count();
    test_reset_mid_job();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
